// File: rtl/output_argmax_if.sv
// Handshake and output-RAM bus for the argmax scanner.
interface output_argmax_if #(
  parameter int DEPTH      = 10,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         rdaddr;
  logic [DATA_WIDTH-1:0] q;
  logic [AW-1:0]         class_idx;
  logic [DATA_WIDTH-1:0] class_val;
  logic                  result_valid;

  modport master (
    output start, q,
    input  busy, done, rdaddr, class_idx, class_val, result_valid
  );

  modport slave (
    input  start, q,
    output busy, done, rdaddr, class_idx, class_val, result_valid
  );
endinterface

// File: rtl/output_argmax.sv
// Scans DEPTH signed entries of the layer output RAM and reports the index and
// value of the maximum (lowest index wins ties).
module output_argmax #(
  parameter int DEPTH      = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  output_argmax_if.slave  bus
);
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t                       state, state_nx;
  logic [AW-1:0]                addr_cnt;
  logic                         vld_d;
  logic [AW-1:0]                idx_d;
  logic signed [DATA_WIDTH-1:0] max_val, cand_val;
  logic [AW-1:0]                max_idx, cand_idx;
  logic [AW-1:0]                class_idx_r;
  logic [DATA_WIDTH-1:0]        class_val_r;
  logic                         result_valid_r;
  logic                         take_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SCAN;
      SCAN:    if (addr_cnt == LAST) state_nx = DRAIN;
      DRAIN:   state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == FINISH);
    bus.rdaddr = (state == SCAN) ? addr_cnt : '0;
  end

  // q belongs to the address issued last cycle; idx 0 always seeds the max
  always_comb begin
    take_q   = vld_d && ((idx_d == '0) || ($signed(bus.q) > max_val));
    cand_val = take_q ? $signed(bus.q) : max_val;
    cand_idx = take_q ? idx_d : max_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt       <= '0;
      vld_d          <= 1'b0;
      idx_d          <= '0;
      max_val        <= '0;
      max_idx        <= '0;
      class_idx_r    <= '0;
      class_val_r    <= '0;
      result_valid_r <= 1'b0;
    end else begin
      vld_d <= (state == SCAN);
      idx_d <= addr_cnt;
      if (state == SCAN && addr_cnt != LAST) addr_cnt <= addr_cnt + 1'b1;
      else                                   addr_cnt <= '0;
      if (vld_d) begin
        max_val <= cand_val;
        max_idx <= cand_idx;
      end
      if (state == IDLE && bus.start) result_valid_r <= 1'b0;
      // the last entry is compared in DRAIN, so publish the candidate directly
      if (state == DRAIN) begin
        class_val_r    <= cand_val;
        class_idx_r    <= cand_idx;
        result_valid_r <= 1'b1;
      end
    end
  end

  assign bus.class_idx    = class_idx_r;
  assign bus.class_val    = class_val_r;
  assign bus.result_valid = result_valid_r;
endmodule

// File: doc/output_argmax.md
OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 SHALL have parameter DEPTH, default 10: number of entries scanned in the layer output RAM (DEPTH >= 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed entry width (Q-format irrelevant; two's-complement compare only).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin scan; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  single-cycle pulse when result is final.
REQ-009 rdaddr  output  $clog2(DEPTH) (min 1)  output-RAM read address.
REQ-010 q  input  DATA_WIDTH  output-RAM read data; 1-cycle read latency (data for rdaddr at cycle n appears at cycle n+1).
REQ-011 class_idx  output  $clog2(DEPTH) (min 1)  index of maximum entry.
REQ-012 class_val  output  DATA_WIDTH  signed maximum value.
REQ-013 result_valid  output  1  class_idx/class_val hold a completed result.

Function
REQ-014 SHALL implement states IDLE, SCAN, DRAIN, FINISH.
REQ-015 IDLE -> SCAN when start=1; otherwise stay; rdaddr=0 in IDLE.
REQ-016 SCAN: rdaddr = address counter, starting 0, +1 per cycle; after issuing DEPTH-1 -> DRAIN.
REQ-017 DRAIN: one cycle, compares data for address DEPTH-1 -> FINISH.
REQ-018 FINISH: done=1 for exactly this cycle; class_idx/class_val/result_valid already updated and valid in this cycle; -> IDLE.
REQ-019 Timing: start sampled in cycle c0 -> rdaddr=k in cycle c0+1+k -> done in cycle c0+DEPTH+2, exactly.
REQ-020 Compare pipeline: a delayed-valid/delayed-index register tracks which address the current q belongs to; q accepted only when that valid is high.
REQ-021 First accepted entry (index 0) SHALL unconditionally load running max and index.
REQ-022 Later entries replace running max only if q > max (signed, strict); ties keep lowest index.
REQ-023 Running max/index SHALL be copied to class_val/class_idx when entering FINISH; outputs held stable until next completed scan or reset.
REQ-024 result_valid SHALL clear the cycle after a start is accepted and set together with done.
REQ-025 start while busy (SCAN, DRAIN, FINISH) SHALL be ignored; no restart, no queuing.
REQ-026 DEPTH=1: SCAN lasts one cycle (rdaddr=0), done at c0+3, class_idx=0.
REQ-027 No address wrap: counter never exceeds DEPTH-1.

Reset
REQ-028 rst=1 at any clock edge, including mid-scan, SHALL force IDLE and clear busy, done, rdaddr, class_idx, class_val, result_valid, counter, pipeline valid, running max to 0.
REQ-029 First start after reset release SHALL behave identically to REQ-019.

Verification (DEPTH=10, DATA_WIDTH=16)
REQ-030 RAM = [5,-3,100,7,100,0,1,2,3,4], start at c0 -> done only at c12, class_idx=2, class_val=100, result_valid=1; rdaddr sequence 0..9 in c1..c10.
REQ-031 RAM all negative [-9,-2,-5,-7,-8,-6,-4,-3,-10,-11] -> class_idx=1, class_val=-2 (0xFFFE); verifies signed compare and first-entry load.
REQ-032 RAM all 0x0040 -> class_idx=0, class_val=0x0040 (tie rule).
REQ-033 RAM zeros except entry 9 = 0x7FFF, entry 0 = 0x8000 -> class_idx=9, class_val=0x7FFF (drain path, extreme values).
REQ-034 start held high continuously for 30 cycles -> scans restart only from IDLE: done at c12 and c25, no extra pulses; start pulsed at c5 of a scan has no effect.
REQ-035 rst at c6 of a scan -> c7 shows busy=0, result_valid=0, class_idx=0, rdaddr=0; new start at c10 -> done at c22 with correct result.
